// File: rtl/mips_mem_ctrl.sv
// Memory/IO controller behind the multicycle MIPS core: SRAM access with ready handshake plus LED/counter/status IO.
// IO and misaligned accesses complete in cycle 1; SRAM accesses in cycle MEM_LAT+2. cpu_req is held until the cpu_ready pulse.
module mips_mem_ctrl #(
    parameter int          MEM_LAT = 2,
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  io_led,
    output logic        misalign_err
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("mips_mem_ctrl: MEM_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        latch_en;
    logic [31:0] rdata_q, rdata_nxt;
    logic [7:0]  led_q, led_nxt;
    logic        err_q, err_nxt;
    logic [31:0] counter;

    logic        misaligned;
    logic        is_io;
    logic [31:0] io_off;
    logic [31:0] io_rd;

    assign misaligned = (cpu_addr[1:0] != 2'b00);
    assign is_io      = (cpu_addr >= IO_BASE);
    assign io_off     = cpu_addr - IO_BASE;

    always_comb begin
        io_rd = 32'd0;
        case (io_off)
            32'd0:   io_rd = {24'd0, led_q};
            32'd4:   io_rd = counter;
            32'd8:   io_rd = {31'd0, err_q};
            default: io_rd = 32'd0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rdata_nxt    = rdata_q;
        led_nxt      = led_q;
        err_nxt      = err_q;
        latch_en     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (misaligned) begin
                        // Alignment is checked before decode, so misaligned IO also flags.
                        err_nxt = 1'b1;
                        if (!cpu_we) rdata_nxt = 32'd0;
                        state_nxt = DONE;
                    end else if (is_io) begin
                        if (cpu_we) begin
                            if (io_off == 32'd0) led_nxt = cpu_wdata[7:0];
                            if (io_off == 32'd8) err_nxt = 1'b0;
                        end else begin
                            rdata_nxt = io_rd;
                        end
                        state_nxt = DONE;
                    end else begin
                        latch_en     = 1'b1;
                        wait_cnt_nxt = LAT;
                        state_nxt    = RAM_WAIT;
                    end
                end
            end
            RAM_WAIT: begin
                // Counter runs MEM_LAT..0, so the capture lands at the end of cycle 1+MEM_LAT.
                if (wait_cnt == 4'd0) begin
                    if (!we_q) rdata_nxt = mem_rdata;
                    state_nxt = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 30'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            rdata_q  <= 32'd0;
            led_q    <= 8'd0;
            err_q    <= 1'b0;
            counter  <= 32'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rdata_q  <= rdata_nxt;
            led_q    <= led_nxt;
            err_q    <= err_nxt;
            counter  <= counter + 32'd1;
            if (latch_en) begin
                addr_q  <= cpu_addr[31:2];
                wdata_q <= cpu_wdata;
                we_q    <= cpu_we;
            end
        end
    end

    assign mem_en       = (state == RAM_WAIT) && (wait_cnt == LAT);
    assign mem_we       = (state == RAM_WAIT) && we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_ready    = (state == DONE);
    assign cpu_rdata    = rdata_q;
    assign io_led       = led_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Bench for mips_mem_ctrl: directed and random accesses against a transaction-level model, plus reset-abort on a MEM_LAT=4 copy.
module tb_mips_mem_ctrl;

    localparam int          LAT     = 2;
    localparam int          LAT4    = 4;
    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cpu_req, cpu_we, cpu_ready, mem_en, mem_we, misalign_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;
    logic [7:0]  io_led;

    logic        reset4, req4, we4, ready4, en4, mwe4, err4;
    logic [31:0] addr4, wdata4, rdata4, mwdata4, mrdata4;
    logic [29:0] maddr4;
    logic [7:0]  led4;

    mips_mem_ctrl #(.MEM_LAT(LAT), .IO_BASE(IO_BASE)) u_dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .io_led(io_led), .misalign_err(misalign_err)
    );

    mips_mem_ctrl #(.MEM_LAT(LAT4), .IO_BASE(IO_BASE)) u_dut4 (
        .clk(clk), .reset(reset4), .cpu_req(req4), .cpu_we(we4), .cpu_addr(addr4),
        .cpu_wdata(wdata4), .cpu_rdata(rdata4), .cpu_ready(ready4), .mem_en(en4),
        .mem_we(mwe4), .mem_addr(maddr4), .mem_wdata(mwdata4), .mem_rdata(mrdata4),
        .io_led(led4), .misalign_err(err4)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEAD_BEEF;
        return 32'hA000_0000 ^ 32'(i * 32'h0101_0013);
    endfunction

    // SRAM device for the main DUT: data appears MEM_LAT cycles after the strobe cycle.
    logic        sram_init;
    logic [31:0] sram [256];
    logic [31:0] pipe2 [LAT];
    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            sram[mem_addr[7:0]] <= mem_wdata;
        end
        pipe2[0] <= (mem_en && !mem_we) ? sram[mem_addr[7:0]] : $urandom;
        for (int i = 1; i < LAT; i++) pipe2[i] <= pipe2[i-1];
    end
    assign mem_rdata = pipe2[LAT-1];

    logic [31:0] pipe4 [LAT4];
    always @(posedge clk) begin
        pipe4[0] <= (en4 && !mwe4) ? ({2'b00, maddr4} ^ 32'h5A5A_0000) : $urandom;
        for (int i = 1; i < LAT4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign mrdata4 = pipe4[LAT4-1];

    // Cycles elapsed since reset release: the expected COUNTER value.
    int unsigned tb_cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [256];
    logic [7:0]  ref_led;
    logic        ref_err;
    logic [31:0] ref_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_ctl"}, {28'd0, cpu_ready, mem_en, mem_we, misalign_err}, 32'd0);
        chk({tag, "_maddr"}, {2'b00, mem_addr}, 32'd0);
        chk({tag, "_mwdata"}, mem_wdata, 32'd0);
        chk({tag, "_led"}, {24'd0, io_led}, 32'd0);
    endtask

    // One transaction on the main DUT; called one step after a rising edge with the DUT idle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] cnt0, off, en_wd;
        logic [29:0] en_addr;
        logic        en_we, got;
        int          exp_lat, exp_en, n, en_cnt, en_n;
        cnt0 = tb_cyc;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        exp_en = 0; exp_lat = 1;
        if (addr[1:0] != 2'b00) begin
            ref_err = 1'b1;
            if (!we) ref_rdata = 32'd0;
        end else if (addr >= IO_BASE) begin
            off = addr - IO_BASE;
            if (we) begin
                if (off == 32'd0) ref_led = wdata[7:0];
                if (off == 32'd8) ref_err = 1'b0;
            end else begin
                ref_rdata = (off == 32'd0) ? {24'd0, ref_led} :
                            (off == 32'd4) ? cnt0 :
                            (off == 32'd8) ? {31'd0, ref_err} : 32'd0;
            end
        end else begin
            exp_en = 1; exp_lat = LAT + 2;
            if (we) ref_mem[addr[9:2]] = wdata;
            else    ref_rdata = ref_mem[addr[9:2]];
        end
        n = 0; en_cnt = 0; en_n = 0; got = 1'b0;
        en_addr = '0; en_we = 1'b0; en_wd = '0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (mem_en) begin
                en_cnt++; en_n = n;
                en_addr = mem_addr; en_we = mem_we; en_wd = mem_wdata;
            end
            got = cpu_ready;
        end
        cpu_req = 1'b0;
        chk("ready_latency", n, exp_lat);
        chk("rdata", cpu_rdata, ref_rdata);
        chk("io_led", {24'd0, io_led}, {24'd0, ref_led});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, ref_err});
        chk("mem_en_count", en_cnt, exp_en);
        if (exp_en == 1) begin
            chk("mem_en_cycle", en_n, 1);
            chk("mem_addr", {2'b00, en_addr}, {2'b00, addr[31:2]});
            chk("mem_we", {31'd0, en_we}, {31'd0, we});
            if (we) chk("mem_wdata", en_wd, wdata);
        end
        @(posedge clk); #1;
        chk("ready_one_cycle", {31'd0, cpu_ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        int          k, n;
        logic        seen;
        logic [31:0] offs_rd [5];
        logic [31:0] offs_wr [4];
        offs_rd = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        offs_wr = '{32'h0, 32'h4, 32'h8, 32'h20};

        reset = 1'b0; reset4 = 1'b0; sram_init = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        req4 = 0; we4 = 0; addr4 = 0; wdata4 = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        ref_led = 8'd0; ref_err = 1'b0; ref_rdata = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        sram_init = 1'b0; reset = 1'b1; reset4 = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 32'h0000_0100, 32'd0);
        chk("deadbeef", cpu_rdata, 32'hDEAD_BEEF);
        access(1'b1, 32'h0000_0200, 32'h1234_5678);
        chk("write_keeps_rdata", cpu_rdata, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0200, 32'd0);
        access(1'b1, IO_BASE, 32'h0000_01A5);
        chk("led_a5", {24'd0, io_led}, 32'h0000_00A5);
        access(1'b0, IO_BASE, 32'd0);
        access(1'b0, IO_BASE + 32'h10, 32'd0);
        access(1'b0, 32'h0000_0102, 32'd0);
        access(1'b0, IO_BASE + 32'h8, 32'd0);
        chk("status_set", cpu_rdata, 32'd1);
        access(1'b1, IO_BASE + 32'h8, 32'hFFFF_FFFF);
        access(1'b0, IO_BASE + 32'h8, 32'd0);

        // Held request: DONE must not accept, so IO completions are two cycles apart.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = IO_BASE;
        @(posedge clk); #1; chk("held_ready_c1", {31'd0, cpu_ready}, 32'd1);
        @(posedge clk); #1; chk("held_ready_c2", {31'd0, cpu_ready}, 32'd0);
        @(posedge clk); #1; chk("held_ready_c3", {31'd0, cpu_ready}, 32'd1);
        cpu_req = 1'b0;
        ref_rdata = {24'd0, ref_led};
        @(posedge clk); #1;

        for (int it = 0; it < 80; it++) begin
            k = $urandom_range(0, 9);
            d = $urandom;
            a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if (k <= 3)      access(1'b0, a, 32'd0);
            else if (k <= 5) access(1'b1, a, d);
            else if (k <= 7) access(1'b0, IO_BASE + offs_rd[$urandom_range(0, 4)], 32'd0);
            else if (k == 8) access(1'b1, IO_BASE + offs_wr[$urandom_range(0, 3)], d);
            else begin
                a[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) a = IO_BASE + {30'd0, a[1:0]};
                access(1'b0, a, 32'd0);
            end
        end

        // Mid-stream reset on the main DUT.
        access(1'b1, IO_BASE, 32'h0000_003C);
        access(1'b0, 32'h0000_0001, 32'd0);
        reset = 1'b0;
        #1; chk_reset_outputs("rst_async");
        repeat (3) @(posedge clk);
        #1; chk_reset_outputs("rst_held");
        ref_led = 8'd0; ref_err = 1'b0; ref_rdata = 32'd0;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        access(1'b0, IO_BASE + 32'h4, 32'd0);
        chk("counter_after_reset", cpu_rdata, 32'd10);

        // Reset during RAM_WAIT on the MEM_LAT=4 copy aborts the access.
        req4 = 1'b1; we4 = 1'b0; addr4 = 32'h0000_0040;
        @(posedge clk); #1;
        chk("abort_mem_en_c1", {31'd0, en4}, 32'd1);
        reset4 = 1'b0;
        #1;
        chk("abort_mem_en_drop", {31'd0, en4}, 32'd0);
        req4 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) reset4 = 1'b1;
            @(posedge clk); #1;
            if (en4 || ready4) seen = 1'b1;
        end
        chk("abort_no_ready", {31'd0, seen}, 32'd0);
        req4 = 1'b1; addr4 = 32'h0000_0000;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            seen = ready4;
        end
        req4 = 1'b0;
        chk("lat4_ready_cycle", n, 6);
        chk("lat4_rdata", rdata4, 32'h5A5A_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
